// File: rtl/icache_direct_if.sv
// Core-fetch and memory-controller signal bundle for icache_direct.
// Latency: n/a (wires only). Backpressure: the controller stalls fills by holding iwait high.
// Ports: slave = cache view, master = core + controller (environment) view.
interface icache_direct_if #(
  parameter int CNTW = 32
);
  // core fetch side
  logic            imemREN;
  logic [31:0]     imemaddr;
  logic [31:0]     imemload;
  logic            ihit;
  logic            flush;
  // memory controller side
  logic            iREN;
  logic [31:0]     iaddr;
  logic            iwait;
  logic [31:0]     iload;
  // performance counters
  logic [CNTW-1:0] hit_count;
  logic [CNTW-1:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output imemload, ihit, iREN, iaddr, hit_count, miss_count
  );

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  imemload, ihit, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache, one word per line, with hit/miss counters.
// Latency: hits return combinationally; a miss costs the miss cycle plus >=1 FETCH cycle.
// Backpressure: the core sees ihit=0 until the fill lands; iwait=1 holds the fetch (iREN/iaddr stable).
// Ports: CLK, RST (sync, active-high), bus (icache_direct_if.slave: core fetch + controller read port).
module icache_direct #(
  parameter int SETS = 16,
  parameter int CNTW = 32
) (
  input  logic           CLK,
  input  logic           RST,
  icache_direct_if.slave bus
);

  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 32 - IDX - 2;

  typedef enum logic {
    COMPARE = 1'b0,
    FETCH   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [SETS-1:0]   valid_q;
  logic [TAGW-1:0]   tag_q  [SETS];
  logic [31:0]       data_q [SETS];
  logic [31:0]       miss_addr_q, miss_addr_d;
  logic [CNTW-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNTW-1:0]   miss_cnt_q, miss_cnt_d;

  logic [IDX-1:0]    req_idx;
  logic [TAGW-1:0]   req_tag;
  logic [IDX-1:0]    fill_idx;
  logic [TAGW-1:0]   fill_tag;
  logic              hit;
  logic              fill_en;

  assign req_idx  = bus.imemaddr[IDX+1:2];
  assign req_tag  = bus.imemaddr[31:IDX+2];
  assign fill_idx = miss_addr_q[IDX+1:2];
  assign fill_tag = miss_addr_q[31:IDX+2];

  // Lookup only in COMPARE; during FETCH the core is stalled regardless of its address.
  assign hit = (state_q == COMPARE) && bus.imemREN && valid_q[req_idx] &&
               (tag_q[req_idx] == req_tag);

  assign bus.ihit       = hit;
  assign bus.imemload   = hit ? data_q[req_idx] : 32'h0;
  assign bus.iREN       = (state_q == FETCH);
  assign bus.iaddr      = (state_q == FETCH) ? miss_addr_q : 32'h0;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    fill_en     = 1'b0;
    case (state_q)
      COMPARE: begin
        if (hit) begin
          hit_cnt_d = hit_cnt_q + CNTW'(1);
        end else if (bus.imemREN) begin
          // Masking keeps the controller address word-aligned.
          miss_addr_d = bus.imemaddr & 32'hFFFF_FFFC;
          miss_cnt_d  = miss_cnt_q + CNTW'(1);
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (!bus.iwait) begin
          fill_en = 1'b1;
          state_d = COMPARE;
        end
      end
      default: state_d = COMPARE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= COMPARE;
      valid_q     <= '0;
      miss_addr_q <= 32'h0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      // Flush beats a coincident fill: the line is written but left invalid.
      if (bus.flush) begin
        valid_q <= '0;
      end else if (fill_en) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data arrays need no reset; valid bits alone qualify their contents.
  always_ff @(posedge CLK) begin
    if (fill_en && !RST) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.iload;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed vector table, reset-mid-fetch sequence,
// and randomized transactions against a line-level reference model.
module tb_icache_direct;
  localparam int SETS = 16;
  localparam int IDX  = 4;
  localparam int CNTW = 32;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  icache_direct_if #(.CNTW(CNTW)) bus();

  icache_direct #(.SETS(SETS), .CNTW(CNTW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          ren;
    logic [31:0] addr;
    bit          fl;
    bit          w;
    logic [31:0] ld;
    bit          eh;
    logic [31:0] el;
    bit          er;
    logic [31:0] ea;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit ren, input logic [31:0] addr, input bit fl, input bit w,
                              input logic [31:0] ld, input bit eh, input logic [31:0] el,
                              input bit er, input logic [31:0] ea);
    vec_t v;
    v.ren = ren; v.addr = addr; v.fl = fl; v.w = w; v.ld = ld;
    v.eh = eh; v.el = el; v.er = er; v.ea = ea;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later, far from the rising edge.
  task automatic drive(input bit ren, input logic [31:0] a, input bit fl, input bit w,
                       input logic [31:0] ld);
    @(negedge CLK);
    bus.imemREN  = ren;
    bus.imemaddr = a;
    bus.flush    = fl;
    bus.iwait    = w;
    bus.iload    = ld;
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    bus.imemREN = 1'b0; bus.imemaddr = 32'h0; bus.flush = 1'b0;
    bus.iwait = 1'b1; bus.iload = 32'h0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0BAD_F00D;
  endfunction

  // Reference model: which word address each line currently holds.
  bit          mv    [SETS];
  logic [31:0] mword [SETS];
  int          rh, rm;

  initial begin
    int exp_h, exp_m;
    logic [31:0] a, al;
    int idx, nw;
    bit fl, mhit;

    // ---------------- directed vector table ----------------
    //   ren addr           fl w ld            eh el            er ea
    add(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);   // cold miss
    add(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        1, 32'h40);
    add(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        1, 32'h40);
    add(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        1, 32'h40);
    add(1, 32'h40,  0, 0, 32'hDEADBEEF, 0, 32'h0,        1, 32'h40);  // fill
    add(1, 32'h40,  0, 1, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0);
    add(1, 32'h43,  0, 1, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0);   // unaligned
    add(0, 32'h40,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);   // idle
    add(1, 32'h0,   0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
    add(1, 32'h0,   0, 0, 32'h11111111, 0, 32'h0,        1, 32'h0);
    add(1, 32'h4,   0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
    add(1, 32'h4,   0, 0, 32'h22222222, 0, 32'h0,        1, 32'h4);
    for (int i = 0; i < 10; i++) begin                                // hit streak
      if (i % 2 == 0) add(1, 32'h0, 0, 1, 32'h0, 1, 32'h11111111, 0, 32'h0);
      else            add(1, 32'h4, 0, 1, 32'h0, 1, 32'h22222222, 0, 32'h0);
    end
    add(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);   // evicted by 0x0
    add(1, 32'h40,  0, 0, 32'hAAAA0040, 0, 32'h0,        1, 32'h40);
    add(1, 32'h0,   0, 1, 32'h0,        0, 32'h0,        0, 32'h0);   // evicted by 0x40
    add(1, 32'h0,   0, 0, 32'h11111111, 0, 32'h0,        1, 32'h0);
    add(1, 32'h0,   0, 1, 32'h0,        1, 32'h11111111, 0, 32'h0);
    add(1, 32'h100, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0);   // addr change mid-miss
    add(1, 32'h200, 0, 1, 32'h0,        0, 32'h0,        1, 32'h100);
    add(1, 32'h200, 0, 0, 32'h01000100, 0, 32'h0,        1, 32'h100);
    add(1, 32'h100, 0, 1, 32'h0,        1, 32'h01000100, 0, 32'h0);
    add(1, 32'h200, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
    add(1, 32'h200, 0, 0, 32'h02000200, 0, 32'h0,        1, 32'h200);
    add(1, 32'h200, 0, 1, 32'h0,        1, 32'h02000200, 0, 32'h0);
    add(1, 32'h80,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);   // flush at fill completion
    add(1, 32'h80,  1, 0, 32'h08080808, 0, 32'h0,        1, 32'h80);
    add(1, 32'h80,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
    add(1, 32'h80,  0, 0, 32'h08080808, 0, 32'h0,        1, 32'h80);
    add(1, 32'h80,  0, 1, 32'h0,        1, 32'h08080808, 0, 32'h0);
    add(1, 32'h4,   0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
    add(1, 32'h4,   0, 0, 32'h22222222, 0, 32'h0,        1, 32'h4);
    add(1, 32'h4,   1, 1, 32'h0,        1, 32'h22222222, 0, 32'h0);   // flush in COMPARE, hit uses old
    add(1, 32'h80,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
    add(1, 32'h80,  0, 0, 32'h08080808, 0, 32'h0,        1, 32'h80);
    add(1, 32'h4,   0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
    add(1, 32'h4,   1, 1, 32'h0,        0, 32'h0,        1, 32'h4);   // flush during wait
    add(1, 32'h4,   0, 0, 32'h22222222, 0, 32'h0,        1, 32'h4);
    add(1, 32'h4,   0, 1, 32'h0,        1, 32'h22222222, 0, 32'h0);   // fill survived
    add(1, 32'h80,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
    add(1, 32'h80,  0, 0, 32'h08080808, 0, 32'h0,        1, 32'h80);
    add(0, 32'h0,   0, 1, 32'h0,        0, 32'h0,        0, 32'h0);

    do_reset();
    drive(0, 32'h0, 0, 1, 32'h0);
    chk("reset ihit", 32'(bus.ihit), 32'h0);
    chk("reset imemload", bus.imemload, 32'h0);
    chk("reset iREN", 32'(bus.iREN), 32'h0);
    chk("reset iaddr", bus.iaddr, 32'h0);
    chk("reset hit_count", bus.hit_count, 32'h0);
    chk("reset miss_count", bus.miss_count, 32'h0);

    exp_h = 0;
    exp_m = 0;
    foreach (vecs[i]) begin
      drive(vecs[i].ren, vecs[i].addr, vecs[i].fl, vecs[i].w, vecs[i].ld);
      chk($sformatf("row%0d ihit", i), 32'(bus.ihit), 32'(vecs[i].eh));
      chk($sformatf("row%0d imemload", i), bus.imemload, vecs[i].el);
      chk($sformatf("row%0d iREN", i), 32'(bus.iREN), 32'(vecs[i].er));
      chk($sformatf("row%0d iaddr", i), bus.iaddr, vecs[i].ea);
      chk($sformatf("row%0d hit_count", i), bus.hit_count, 32'(exp_h));
      chk($sformatf("row%0d miss_count", i), bus.miss_count, 32'(exp_m));
      if (vecs[i].eh) exp_h++;
      if (vecs[i].ren && !vecs[i].eh && !vecs[i].er) exp_m++;
    end
    drive(0, 32'h0, 0, 1, 32'h0);
    chk("table hit_count", bus.hit_count, 32'(exp_h));
    chk("table miss_count", bus.miss_count, 32'(exp_m));

    // ---------------- reset during FETCH ----------------
    drive(1, 32'h300, 0, 1, 32'h0);
    chk("rstfetch miss ihit", 32'(bus.ihit), 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rstfetch iREN before", 32'(bus.iREN), 32'h1);
    chk("rstfetch iaddr before", bus.iaddr, 32'h300);
    @(negedge CLK);
    RST = 1'b0;
    bus.imemREN = 1'b0;
    #1;
    chk("rstfetch iREN after", 32'(bus.iREN), 32'h0);
    chk("rstfetch iaddr after", bus.iaddr, 32'h0);
    chk("rstfetch hit_count", bus.hit_count, 32'h0);
    chk("rstfetch miss_count", bus.miss_count, 32'h0);
    drive(1, 32'h300, 0, 1, 32'h0);
    chk("rstfetch remiss ihit", 32'(bus.ihit), 32'h0);
    chk("rstfetch remiss iREN", 32'(bus.iREN), 32'h0);
    drive(1, 32'h300, 0, 0, 32'h33333333);
    chk("rstfetch refill iaddr", bus.iaddr, 32'h300);
    chk("rstfetch miss_count 1", bus.miss_count, 32'h1);
    drive(1, 32'h4, 0, 1, 32'h0);
    chk("rstfetch old line gone", 32'(bus.ihit), 32'h0);
    drive(1, 32'h4, 0, 0, 32'h22222222);
    drive(1, 32'h300, 0, 1, 32'h0);
    chk("rstfetch hit ihit", 32'(bus.ihit), 32'h1);
    chk("rstfetch hit data", bus.imemload, 32'h33333333);

    // ---------------- randomized transactions vs model ----------------
    do_reset();
    for (int s = 0; s < SETS; s++) mv[s] = 1'b0;
    rh = 0;
    rm = 0;
    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        fl = ($urandom_range(0, 1) == 1);
        drive(0, $urandom, fl, 1, $urandom);
        chk("rnd idle ihit", 32'(bus.ihit), 32'h0);
        chk("rnd idle imemload", bus.imemload, 32'h0);
        if (fl) for (int s = 0; s < SETS; s++) mv[s] = 1'b0;
      end
      idx = $urandom_range(0, SETS - 1);
      a   = (32'($urandom_range(0, 3)) << (IDX + 2)) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
      al  = a & 32'hFFFF_FFFC;
      drive(1, a, 0, 1, $urandom);
      chk("rnd hit_count", bus.hit_count, 32'(rh));
      chk("rnd miss_count", bus.miss_count, 32'(rm));
      mhit = mv[idx] && (mword[idx] == al);
      chk($sformatf("rnd ihit @%h", a), 32'(bus.ihit), 32'(mhit));
      if (mhit) begin
        chk($sformatf("rnd data @%h", a), bus.imemload, memfn(al));
        rh++;
      end else begin
        chk("rnd miss iREN", 32'(bus.iREN), 32'h0);
        rm++;
        nw = $urandom_range(0, 3);
        for (int w = 0; w < nw; w++) begin
          fl = ($urandom_range(0, 5) == 0);
          drive($urandom_range(0, 1) == 1, $urandom, fl, 1, $urandom);
          chk("rnd wait iREN", 32'(bus.iREN), 32'h1);
          chk("rnd wait iaddr", bus.iaddr, al);
          chk("rnd wait ihit", 32'(bus.ihit), 32'h0);
          if (fl) for (int s = 0; s < SETS; s++) mv[s] = 1'b0;
        end
        fl = ($urandom_range(0, 5) == 0);
        drive(1, $urandom, fl, 0, memfn(al));
        chk("rnd fill iREN", 32'(bus.iREN), 32'h1);
        chk("rnd fill iaddr", bus.iaddr, al);
        if (fl) begin
          for (int s = 0; s < SETS; s++) mv[s] = 1'b0;
        end else begin
          mv[idx]    = 1'b1;
          mword[idx] = al;
        end
      end
    end
    drive(0, 32'h0, 0, 1, 32'h0);
    chk("rnd final hit_count", bus.hit_count, 32'(rh));
    chk("rnd final miss_count", bus.miss_count, 32'(rm));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache for one core, one word per block.
- Sits between the core fetch stage and the memory controller's per-core instruction port (iREN/iaddr/iwait/iload).
- Services hits combinationally in the same cycle.
- On a miss, issues one word read to the memory controller and holds it until iwait drops, then fills the line.
- Keeps hit and miss counters for performance checks.

Parameters:
SETS, 16, number of lines; power of two, 2..256; IDX = log2(SETS)
CNTW, 32, width of the hit/miss counters

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
imemREN  in  1  core fetch request
imemaddr  in  32  core fetch byte address; bits [1:0] ignored
imemload  out  32  instruction returned to the core; valid when ihit=1
ihit  out  1  request satisfied this cycle
flush  in  1  invalidate every line
iREN  out  1  read request to the memory controller
iaddr  out  32  word-aligned read address to the memory controller
iwait  in  1  memory controller busy; 0 = iload valid this cycle
iload  in  32  read data from the memory controller
hit_count  out  CNTW  number of hit cycles
miss_count  out  CNTW  number of misses taken

Behaviour:
- Address split: index = imemaddr[IDX+1:2]; tag = imemaddr[31:IDX+2]; offset bits [1:0] ignored.
- Storage per line: valid bit, tag, 32-bit data word.
- One clock, CLK. Reset is synchronous and active-high on RST; all state changes on the CLK rising edge.
- Reset, at the first rising edge with RST=1:
  - all valid bits 0; state COMPARE; both counters 0; miss address register 0.
  - outputs after reset: iREN=0, iaddr=0, ihit=0, imemload=0.
- FSM has two states, COMPARE and FETCH.
- COMPARE:
  - hit = imemREN & valid[index] & (tag match).
  - On hit: ihit=1 and imemload=data[index], combinationally in the same cycle; hit_count increments.
  - On imemREN with no hit: latch {imemaddr[31:2],2'b00} into miss_addr; miss_count increments; go to FETCH; ihit=0.
  - With imemREN=0: ihit=0, imemload=0, no state change.
  - iREN=0 and iaddr=0 throughout.
- FETCH:
  - iREN=1 and iaddr=miss_addr, held stable until completion; ihit=0; imemload=0.
  - iwait=1: stay in FETCH.
  - iwait=0: write data=iload, tag and valid=1 into the line at miss_addr's index, then go to COMPARE.
  - The next cycle then hits if the core still presents the same address.
  - Minimum miss latency: miss cycle, then 1 FETCH cycle, then the hit cycle, i.e. 2 cycles before ihit.
- Changes to imemaddr or imemREN during FETCH are ignored; the latched fill always completes. The controller must never see iREN drop mid-transaction.
- Replacement: a fill overwrites whatever occupies the index (conflict eviction); no writeback, since the cache is read-only.
- flush:
  - In COMPARE: clears all valid bits at the edge; same-cycle hit evaluation still uses the pre-flush contents.
  - In FETCH with iwait=1: clears valids and the fill still completes valid.
  - Coincident with fill completion (flush=1 and iwait=0 in FETCH): clears valids and the filled line is written with valid=0; flush has priority.
- Counters wrap modulo 2^CNTW; they are not saturating.
- RST during FETCH: return to COMPARE with iREN=0 after the edge; the pending fill is discarded.

Test Plan:
- Reset then cold miss: RST 1 cycle; imemREN=1, imemaddr=0x0000_0040; controller holds iwait=1 for 3 cycles then iwait=0 with iload=0xDEAD_BEEF -> iaddr=0x40 and iREN=1 for 4 cycles; next cycle ihit=1 and imemload=0xDEADBEEF; miss_count=1, hit_count=1.
- Hit streak: fill 0x0 and 0x4, then alternate reads over 10 cycles -> ihit=1 every cycle, iREN=0 throughout, hit_count=10.
- Conflict eviction (SETS=16): fill 0x0000_0000, then read 0x0000_0040 (same index 0, different tag) -> miss and refill; then reading 0x0 misses again; miss_count=3.
- Address change mid-miss: miss on 0x100; during FETCH switch imemaddr to 0x200 -> iaddr stays 0x100 until iwait=0; line for 0x100 valid; the 0x200 request then misses.
- Flush priority: flush=1 in the same cycle as fill completion for 0x80 -> next read of 0x80 misses. Flush in COMPARE after lines 0x0 and 0x4 are filled -> both miss afterwards.
- Reset mid-fetch: RST during FETCH with iwait=1 -> iREN=0 next cycle; counters 0; the previous address misses again.
- Unaligned address: read 0x43 after 0x40 was filled -> ihit=1 with the same data; iaddr on a miss is always word-aligned.
